// File: rtl/servile_wb_timer_if.sv
// Wishbone bundle between the servile bus mux ext port and the mtime/mtimecmp timer.
interface servile_wb_timer_if;
    logic [31:0] i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_stb;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_stb,
        input  o_wb_rdt, o_wb_ack
    );

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_stb,
        output o_wb_rdt, o_wb_ack
    );
endinterface

// File: rtl/servile_wb_timer.sv
// RISC-V style 64-bit mtime/mtimecmp timer on the servile ext Wishbone port.
// Optional macro SERVILE_TIMER_SNAPSHOT_EN: a MTIME_LO read latches mtime[63:32] for the next MTIME_HI read.
module servile_wb_timer #(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    servile_wb_timer_if.slave wb,
    output logic              o_timer_irq
);

    localparam logic [1:0]  REG_MTIME_LO = 2'd0;
    localparam logic [1:0]  REG_MTIME_HI = 2'd1;
    localparam logic [1:0]  REG_CMP_LO   = 2'd2;
    localparam logic [1:0]  REG_CMP_HI   = 2'd3;
    localparam logic [15:0] PS_LAST      = 16'(PRESCALE - 32'd1);

    logic [15:0] ps_cnt_q, ps_cnt_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        ack_q, ack_d;
    logic [31:0] rdt_q, rdt_d;
    logic        irq_q, irq_d;

    logic        access_s;
    logic        wr_s;
    logic        rd_s;
    logic        tick_s;
    logic [1:0]  reg_sel_s;
    logic [31:0] rd_data_s;
    logic [31:0] mtime_hi_rd_s;
    logic        unused_adr_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? wdat[b*8 +: 8] : cur[b*8 +: 8];
        end
        return res;
    endfunction

    assign unused_adr_s = ^{wb.i_wb_adr[31:4], wb.i_wb_adr[1:0]};

    // Access qualification: a held strobe only counts again once ack has dropped.
    always_comb begin
        access_s  = wb.i_wb_stb & ~ack_q;
        wr_s      = access_s & wb.i_wb_we & (wb.i_wb_sel != 4'b0000);
        rd_s      = access_s & ~wb.i_wb_we;
        reg_sel_s = wb.i_wb_adr[3:2];
        tick_s    = (ps_cnt_q == PS_LAST);
    end

`ifdef SERVILE_TIMER_SNAPSHOT_EN
    logic [31:0] shadow_q, shadow_d;

    assign mtime_hi_rd_s = shadow_q;

    // Shadow of mtime[63:32]: captured by LO reads, overwritten by HI writes.
    always_comb begin
        shadow_d = shadow_q;
        if (rd_s && (reg_sel_s == REG_MTIME_LO)) begin
            shadow_d = mtime_q[63:32];
        end else if (wr_s && (reg_sel_s == REG_MTIME_HI)) begin
            shadow_d = mtime_d[63:32];
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Shadow register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow_q <= 32'd0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    assign mtime_hi_rd_s = mtime_q[63:32];
`endif

    // Read data selection.
    always_comb begin
        rd_data_s = 32'd0;
        case (reg_sel_s)
            REG_MTIME_LO: rd_data_s = mtime_q[31:0];
            REG_MTIME_HI: rd_data_s = mtime_hi_rd_s;
            REG_CMP_LO:   rd_data_s = mtimecmp_q[31:0];
            REG_CMP_HI:   rd_data_s = mtimecmp_q[63:32];
            default:      rd_data_s = 32'd0;
        endcase
    end

    // Next-state: prescaler, mtime (software write beats the tick), mtimecmp, bus response, irq.
    always_comb begin
        ps_cnt_d   = ps_cnt_q;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;

        if (tick_s) begin
            ps_cnt_d = 16'd0;
            mtime_d  = mtime_q + 64'd1;
        end else begin
            ps_cnt_d = ps_cnt_q + 16'd1;
        end

        if (wr_s) begin
            case (reg_sel_s)
                REG_MTIME_LO: mtime_d = {mtime_q[63:32],
                                         merge_bytes(mtime_q[31:0], wb.i_wb_dat, wb.i_wb_sel)};
                REG_MTIME_HI: mtime_d = {merge_bytes(mtime_q[63:32], wb.i_wb_dat, wb.i_wb_sel),
                                         mtime_q[31:0]};
                REG_CMP_LO:   mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wb.i_wb_dat,
                                                              wb.i_wb_sel);
                REG_CMP_HI:   mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wb.i_wb_dat,
                                                              wb.i_wb_sel);
                default:      mtimecmp_d = mtimecmp_q;
            endcase
        end else begin
            mtimecmp_d = mtimecmp_q;
        end

        ack_d = wb.i_wb_stb & ~ack_q;
        rdt_d = rd_s ? rd_data_s : 32'd0;
        irq_d = (mtime_d >= mtimecmp_d);
    end

    // State registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ps_cnt_q   <= 16'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= RESET_CMP;
            ack_q      <= 1'b0;
            rdt_q      <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            ps_cnt_q   <= ps_cnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ack_q      <= ack_d;
            rdt_q      <= rdt_d;
            irq_q      <= irq_d;
        end
    end

    assign wb.o_wb_ack = ack_q;
    assign wb.o_wb_rdt = rdt_q;
    assign o_timer_irq = irq_q;

endmodule
